// File: rtl/ram_master_if.sv
// CPU-side request/response and RAM2 strobe/ready signals bundled for ram_master.
// The master modport is the ram_master view; slave is the core + RAM side.
interface ram_master_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_err;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_busy, cpu_done, cpu_rdata, cpu_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_busy, cpu_done, cpu_rdata, cpu_err,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_master.sv
// Single-outstanding RAM2 initiator: IDLE -> ACCESS (strobe until ready) -> GAP -> IDLE.
// Optional access timeout/abort enabled by defining RAM_MASTER_TIMEOUT_EN.
module ram_master #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TW      = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_master_if.master bus
);

  if ((64'(1) << TW) <= 64'(TIMEOUT)) begin : g_tw_check
    $error("ram_master: TW too narrow to count to TIMEOUT");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          abort_c;

`ifdef RAM_MASTER_TIMEOUT_EN
  logic [TW-1:0] cnt_q, cnt_d;

  // Abort on the TIMEOUT-th ACCESS edge; a coincident mem_ready takes priority.
  assign abort_c = (state_q == S_ACCESS) && !bus.mem_ready &&
                   (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && bus.cpu_req) begin
      cnt_d = '0;
    end else if (state_q == S_ACCESS) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign abort_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cpu_req) state_d = S_ACCESS;
      S_ACCESS: if (bus.mem_ready || abort_c) state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    re_d    = re_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = bus.cpu_we;
          re_d    = !bus.cpu_we;
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          re_d   = 1'b0;
          we_d   = 1'b0;
          done_d = 1'b1;
          if (re_q) rdata_d = bus.mem_rdata;
        end else if (abort_c) begin
          re_d   = 1'b0;
          we_d   = 1'b0;
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      default: begin
        re_d = 1'b0;
        we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      re_q    <= re_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_busy  = busy_q;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;

endmodule
